// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage hazard and halt controller for a short in-order pipeline.
// Tracks the destination registers of instructions in EX, MEM and WB and holds
// decode when a read-after-write hazard would read stale data. A HALT drains the
// pipeline and then parks the block until reset.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   id_valid       decode holds a real, non-squashed instruction
//   id_rs/id_rt    decode source register selects
//   id_rs_used/id_rt_used  matching source is actually read
//   id_regWrite    decode instruction writes the register file
//   id_writereg    decode destination register
//   id_memRead     decode instruction is a load
//   id_flush       jump / jumpReg in decode
//   id_willBranch  taken branch resolved in decode
//   id_halt        decode instruction is HALT
//   stall          hold PC and IF/ID
//   bubble         load a NOP into ID/EX
//   flush_ifid     squash the instruction entering IF/ID
//   halt_done      pipeline drained after HALT
//   stall_cnt      saturating count of stall cycles
//
// Parameter FWD: 0 = no EX/MEM forwarding, 1 = full forwarding (only load-use stalls).

module hazard_ctrl #(
  parameter int unsigned FWD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic        id_regWrite,
  input  logic [2:0]  id_writereg,
  input  logic        id_memRead,
  input  logic        id_flush,
  input  logic        id_willBranch,
  input  logic        id_halt,
  output logic        stall,
  output logic        bubble,
  output logic        flush_ifid,
  output logic        halt_done,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] rg;
    logic       load;
  } slot_t;

  state_e      state_q, state_d;
  slot_t       ex_q, ex_d;
  // MEM and WB keep only the fields that are ever read: the load flag matters
  // only in EX, and WB is consulted only for occupancy while draining.
  logic        mem_valid_q, mem_valid_d;
  logic [2:0]  mem_reg_q, mem_reg_d;
  logic        wb_valid_q, wb_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        raw_hz;
  logic        issue;
  logic        ex_hit;
  logic        mem_hit;

  always_comb begin
    ex_hit  = (id_rs_used & ex_q.valid & (ex_q.rg == id_rs)) |
              (id_rt_used & ex_q.valid & (ex_q.rg == id_rt));
    mem_hit = (id_rs_used & mem_valid_q & (mem_reg_q == id_rs)) |
              (id_rt_used & mem_valid_q & (mem_reg_q == id_rt));
    // WB never stalls: the register file bypasses write-to-read.
    if (FWD != 0) raw_hz = ex_hit & ex_q.load;
    else          raw_hz = ex_hit | mem_hit;

    stall      = 1'b1;
    bubble     = 1'b1;
    issue      = 1'b0;
    flush_ifid = 1'b0;
    if (state_q == RUN) begin
      stall      = id_valid & raw_hz;
      bubble     = id_valid & raw_hz;
      issue      = id_valid & ~raw_hz;
      flush_ifid = issue & (id_flush | id_willBranch);
    end
    halt_done = (state_q == HALTED);

    // HALT occupies EX as an empty slot so the drain check ignores it.
    ex_d = '0;
    if (issue) begin
      ex_d.valid = id_regWrite & ~id_halt;
      ex_d.rg    = id_writereg;
      ex_d.load  = id_memRead;
    end
    mem_valid_d = ex_q.valid;
    mem_reg_d   = ex_q.rg;
    wb_valid_d  = mem_valid_q;

    state_d = state_q;
    unique case (state_q)
      RUN:    if (issue & id_halt) state_d = DRAIN;
      DRAIN:  if (~ex_q.valid & ~mem_valid_q & ~wb_valid_q) state_d = HALTED;
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      ex_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_reg_q   <= '0;
      wb_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_q        <= ex_d;
      mem_valid_q <= mem_valid_d;
      mem_reg_q   <= mem_reg_d;
      wb_valid_q  <= wb_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: drives a FWD=0 and a FWD=1 instance with identical decode
// inputs and compares both against a reference model that remembers which
// writers were issued one, two and three cycles ago.

module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_rs, id_rt, id_writereg;
  logic        id_rs_used, id_rt_used, id_regWrite, id_memRead;
  logic        id_flush, id_willBranch, id_halt;

  logic        s0, b0, f0, h0;
  logic [15:0] c0;
  logic        s1, b1, f1, h1;
  logic [15:0] c1;

  hazard_ctrl #(.FWD(0)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regWrite(id_regWrite),
    .id_writereg(id_writereg), .id_memRead(id_memRead), .id_flush(id_flush),
    .id_willBranch(id_willBranch), .id_halt(id_halt),
    .stall(s0), .bubble(b0), .flush_ifid(f0), .halt_done(h0), .stall_cnt(c0)
  );

  hazard_ctrl #(.FWD(1)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regWrite(id_regWrite),
    .id_writereg(id_writereg), .id_memRead(id_memRead), .id_flush(id_flush),
    .id_willBranch(id_willBranch), .id_halt(id_halt),
    .stall(s1), .bubble(b1), .flush_ifid(f1), .halt_done(h1), .stall_cnt(c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per instance, history of issued writers (index 0 = issued
  // last cycle), a mode (0 running, 1 draining, 2 halted) and a stall count.
  typedef struct packed {
    logic       v;
    logic [2:0] r;
    logic       ld;
  } ent_t;

  ent_t hist0[$];
  ent_t hist1[$];
  int   mode [2];
  int   cnt  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ent_t e;
    e = '0;
    hist0 = {e, e, e};
    hist1 = {e, e, e};
    mode[0] = 0; mode[1] = 0;
    cnt[0]  = 0; cnt[1]  = 0;
  endtask

  function automatic bit reads(input ent_t e);
    return e.v && ((id_rs_used && e.r == id_rs) || (id_rt_used && e.r == id_rt));
  endfunction

  task automatic model_eval(input int m, output bit st, output bit fl,
                            output bit iss, output bit hd);
    ent_t h[$];
    bit   hz;
    if (m == 0) h = hist0; else h = hist1;
    if (m == 0) hz = reads(h[0]) || reads(h[1]);
    else        hz = reads(h[0]) && h[0].ld;
    st  = (mode[m] != 0) ? 1'b1 : (id_valid && hz);
    iss = (mode[m] == 0) && id_valid && !hz;
    fl  = iss && (id_flush || id_willBranch);
    hd  = (mode[m] == 2);
  endtask

  task automatic model_advance(input int m);
    ent_t h[$];
    ent_t e;
    bit   st, fl, iss, hd, empty;
    model_eval(m, st, fl, iss, hd);
    if (m == 0) h = hist0; else h = hist1;
    if (st && cnt[m] < 65535) cnt[m] = cnt[m] + 1;
    empty = !h[0].v && !h[1].v && !h[2].v;
    e.v  = iss && id_regWrite && !id_halt;
    e.r  = id_writereg;
    e.ld = id_memRead;
    h.push_front(e);
    void'(h.pop_back());
    if (mode[m] == 0 && iss && id_halt) mode[m] = 1;
    else if (mode[m] == 1 && empty)     mode[m] = 2;
    if (m == 0) hist0 = h; else hist1 = h;
  endtask

  task automatic check(input int m);
    bit st, fl, iss, hd;
    model_eval(m, st, fl, iss, hd);
    if (m == 0) begin
      chk("fwd0_stall",  32'(s0), 32'(st));
      chk("fwd0_bubble", 32'(b0), 32'(st));
      chk("fwd0_flush",  32'(f0), 32'(fl));
      chk("fwd0_halt",   32'(h0), 32'(hd));
      chk("fwd0_cnt",    32'(c0), cnt[0]);
    end else begin
      chk("fwd1_stall",  32'(s1), 32'(st));
      chk("fwd1_bubble", 32'(b1), 32'(st));
      chk("fwd1_flush",  32'(f1), 32'(fl));
      chk("fwd1_halt",   32'(h1), 32'(hd));
      chk("fwd1_cnt",    32'(c1), cnt[1]);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, then advance model and DUT.
  task automatic cycle();
    @(negedge clk);
    check(0);
    check(1);
    model_advance(0);
    model_advance(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
    id_regWrite = 0; id_writereg = '0; id_memRead = 0;
    id_flush = 0; id_willBranch = 0; id_halt = 0;
  endtask

  task automatic writer(input logic [2:0] rd, input logic ld);
    idle();
    id_valid = 1; id_regWrite = 1; id_writereg = rd; id_memRead = ld;
  endtask

  task automatic apply_reset();
    rst = 0;
    idle();
    model_reset();
    #2;
    check(0);
    check(1);
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  initial begin
    rst = 1;
    idle();
    #1;
    apply_reset();

    // ALU writer r3 then reader of r3 with FWD=0: two stalls, issue on third cycle.
    writer(3'd3, 1'b0); cycle();
    writer(3'd4, 1'b0); id_rs = 3'd3; id_rs_used = 1;
    cycle(); cycle(); cycle();
    idle();
    chk("raw_alu_cnt0", 32'(c0), 32'd2);
    chk("raw_alu_cnt1", 32'(c1), 32'd0);
    repeat (3) cycle();

    // Load-use vs ALU-use with FWD=1.
    apply_reset();
    writer(3'd2, 1'b1); cycle();
    writer(3'd5, 1'b0); id_rt = 3'd2; id_rt_used = 1;
    cycle(); cycle();
    chk("load_use_cnt1", 32'(c1), 32'd1);
    writer(3'd2, 1'b0); cycle();
    writer(3'd6, 1'b0); id_rs = 3'd2; id_rs_used = 1;
    repeat (3) cycle();
    idle();
    chk("alu_use_cnt1", 32'(c1), 32'd1);
    repeat (3) cycle();

    // Taken branch without hazard, then behind a RAW hazard.
    apply_reset();
    idle(); id_valid = 1; id_rs = 3'd1; id_rs_used = 1; id_willBranch = 1;
    cycle();
    writer(3'd1, 1'b0); cycle();
    idle(); id_valid = 1; id_rs = 3'd1; id_rs_used = 1; id_willBranch = 1;
    repeat (3) cycle();
    idle(); repeat (3) cycle();

    // HALT (with a simultaneous jump) behind two in-flight writers.
    apply_reset();
    writer(3'd1, 1'b0); cycle();
    writer(3'd2, 1'b0); cycle();
    idle(); id_valid = 1; id_halt = 1; id_flush = 1; cycle();
    idle(); repeat (6) cycle();
    chk("halt_done0", 32'(h0), 32'd1);
    chk("halt_stall0", 32'(s0), 32'd1);
    chk("halt_done1", 32'(h1), 32'd1);

    // Reset pulsed mid-drain.
    apply_reset();
    writer(3'd1, 1'b0); cycle();
    writer(3'd2, 1'b0); cycle();
    idle(); id_valid = 1; id_halt = 1; cycle();
    idle(); cycle();
    rst = 0;
    #1;
    chk("mid_rst_stall", 32'(s0), 32'd0);
    chk("mid_rst_halt",  32'(h0), 32'd0);
    chk("mid_rst_cnt",   32'(c0), 32'd0);
    model_reset();
    @(posedge clk); #1 rst = 1;
    writer(3'd7, 1'b0); cycle();
    idle(); cycle();

    // Randomized traffic; reset a while after either instance halts.
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs         = 3'($urandom_range(0, 3));
      id_rt         = 3'($urandom_range(0, 3));
      id_rs_used    = 1'($urandom_range(0, 1));
      id_rt_used    = 1'($urandom_range(0, 1));
      id_regWrite   = 1'($urandom_range(0, 1));
      id_writereg   = 3'($urandom_range(0, 3));
      id_memRead    = ($urandom_range(0, 2) == 0);
      id_flush      = ($urandom_range(0, 7) == 0);
      id_willBranch = ($urandom_range(0, 7) == 0);
      id_halt       = ($urandom_range(0, 40) == 0);
      cycle();
      if ((mode[0] == 2 || mode[1] == 2) && $urandom_range(0, 3) == 0) apply_reset();
    end

    // Saturation of the stall counter while parked in HALTED.
    apply_reset();
    idle(); id_valid = 1; id_halt = 1; cycle();
    idle();
    repeat (65545) cycle();
    chk("sat_cnt0", 32'(c0), 32'h0000FFFF);
    chk("sat_cnt1", 32'(c1), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FWD, default 0: 0 = no EX/MEM forwarding; 1 = full forwarding exists, so only load-use hazards stall.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset.
REQ-004 Port id_valid  input  1  decode stage holds a real, non-squashed instruction.
REQ-005 Port id_rs, id_rt  input  3 each  decode source register selects.
REQ-006 Port id_rs_used, id_rt_used  input  1 each  the matching source is actually read.
REQ-007 Port id_regWrite  input  1  decode instruction writes the register file.
REQ-008 Port id_writereg  input  3  decode destination register.
REQ-009 Port id_memRead  input  1  decode instruction is a load.
REQ-010 Port id_flush  input  1  jump or jumpReg in decode.
REQ-011 Port id_willBranch  input  1  taken branch resolved in decode.
REQ-012 Port id_halt  input  1  decode instruction is HALT.
REQ-013 Port stall  output  1  hold PC and IF/ID register.
REQ-014 Port bubble  output  1  load a NOP into ID/EX this cycle.
REQ-015 Port flush_ifid  output  1  squash the instruction entering IF/ID.
REQ-016 Port halt_done  output  1  pipeline drained after HALT.
REQ-017 Port stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-018 The block SHALL keep a scoreboard of three slots, EX, MEM and WB; each slot holds {valid, reg[2:0], load}.
REQ-019 Issue SHALL be defined as id_valid & ~stall & state==RUN.
REQ-020 Every cycle the scoreboard SHALL shift: WB<=MEM and MEM<=EX. EX SHALL load {id_regWrite, id_writereg, id_memRead} on issue; otherwise EX SHALL load an empty (valid=0) slot.
REQ-021 A source matches a slot when the source is used, the slot is valid, and the slot reg equals the source select. r0 SHALL be treated as an ordinary register.
REQ-022 With FWD=0, raw_hz SHALL be 1 when any used source matches the EX or MEM slot. A WB-slot match SHALL NOT stall, because the register file bypasses write-to-read.
REQ-023 With FWD=1, raw_hz SHALL be 1 only when a used source matches the EX slot and that slot has load=1.
REQ-024 In RUN, stall and bubble SHALL equal id_valid & raw_hz, combinationally in the same cycle.
REQ-025 flush_ifid SHALL equal issue & (id_flush | id_willBranch). A stalled jump or branch SHALL NOT flush until it issues.
REQ-026 FSM states SHALL be RUN, DRAIN and HALTED.
REQ-027 RUN SHALL go to DRAIN on issue & id_halt. The HALT itself SHALL enter EX as an empty slot.
REQ-028 In DRAIN, stall=1 and bubble=1. DRAIN SHALL go to HALTED on the first cycle in which all three slots are invalid.
REQ-029 In HALTED, stall=1, bubble=1, flush_ifid=0 and halt_done=1. HALTED SHALL be held until reset.
REQ-030 id_halt together with id_flush or id_willBranch SHALL take HALT precedence; flush_ifid is still asserted for that cycle.
REQ-031 stall_cnt SHALL increment on every cycle with stall=1 and SHALL saturate at 16'hFFFF with no wrap.
REQ-032 Back-to-back hazards SHALL be handled with no lost or duplicated issue. The instruction held in decode re-evaluates every cycle.

Reset
REQ-033 While rst=0, the following SHALL be forced asynchronously: all slots invalid, state=RUN, stall_cnt=0.
REQ-034 While rst=0 and after reset: stall=0, bubble=0, flush_ifid=0, halt_done=0 (with id_valid=0).
REQ-035 Reset asserted in DRAIN or HALTED SHALL return the block to RUN with an empty scoreboard. There is no residual stall.

Verification
REQ-036 FWD=0: issue ADD writing r3, then SUB using rs=r3 -> stall=1 for exactly 2 cycles, bubble=1 for 2 cycles, issue on cycle 3, stall_cnt=2.
REQ-037 FWD=1: LD writing r2, then ADD using rt=r2 -> 1 stall cycle. ALU writing r2, then ADD using r2 -> 0 stall cycles.
REQ-038 Taken BEQZ issued with no hazard -> flush_ifid=1 for 1 cycle. The same branch behind a RAW hazard -> flush_ifid=0 during stall, then 1 on the issue cycle.
REQ-039 HALT issued behind two in-flight writers -> DRAIN lasts until the slots empty (2 cycles), then halt_done=1 permanently and stall=1.
REQ-040 rst pulsed low mid-DRAIN -> halt_done=0, stall=0 immediately, stall_cnt=0. The next instruction issues normally.
REQ-041 Force 65,540 stall cycles -> stall_cnt holds 16'hFFFF.
